// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI4 slave on a word RAM, INCR bursts, full-width beats.
// Define AXI_SLV_RANGE_CHECK_EN to reject bursts starting outside the RAM.
module axi_slave_ram #(
  parameter logic [31:0] S_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int S_AXI_ID_WIDTH = 1,
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int S_MEM_DEPTH = 1024
) (
  input  logic s_axi_aclk,
  input  logic s_axi_aresetn,
  input  logic [S_AXI_ID_WIDTH-1:0] s_axi_awid,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0] s_axi_awlen,
  input  logic s_axi_awvalid,
  output logic s_axi_awready,
  input  logic [S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic s_axi_wlast,
  input  logic s_axi_wvalid,
  output logic s_axi_wready,
  output logic [S_AXI_ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0] s_axi_bresp,
  output logic s_axi_bvalid,
  input  logic s_axi_bready,
  input  logic [S_AXI_ID_WIDTH-1:0] s_axi_arid,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0] s_axi_arlen,
  input  logic s_axi_arvalid,
  output logic s_axi_arready,
  output logic [S_AXI_ID_WIDTH-1:0] s_axi_rid,
  output logic [S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0] s_axi_rresp,
  output logic s_axi_rlast,
  output logic s_axi_rvalid,
  input  logic s_axi_rready
);
  localparam int SW = S_AXI_DATA_WIDTH / 8;
  localparam int BSH = $clog2(SW);
  localparam int IW = $clog2(S_MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [S_AXI_DATA_WIDTH-1:0] mem [S_MEM_DEPTH];

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - S_SLAVE_BASE_ADDR) >> BSH);
  endfunction

  logic aw_ok, ar_ok;
`ifdef AXI_SLV_RANGE_CHECK_EN
  localparam logic [32:0] SPAN = 33'(S_MEM_DEPTH) * 33'(SW);
  assign aw_ok = {1'b0, s_axi_awaddr - S_SLAVE_BASE_ADDR} < SPAN;
  assign ar_ok = {1'b0, s_axi_araddr - S_SLAVE_BASE_ADDR} < SPAN;
`else
  assign aw_ok = 1'b1;
  assign ar_ok = 1'b1;
`endif

  w_state_t w_state;
  logic [IW-1:0] w_idx;
  logic [7:0] w_len, w_cnt;
  logic w_ok, w_err, w_fire, w_final, w_bad;

  assign w_fire = s_axi_wvalid & s_axi_wready;
  assign w_final = (w_cnt == w_len);
  assign w_bad = (s_axi_wlast != w_final);

  // Write channel FSM: AW latch, beat counting, wlast check, B response
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= 2'b00;
      s_axi_bid <= '0;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_ok <= 1'b0;
      w_err <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            s_axi_wready <= 1'b1;
            s_axi_bid <= s_axi_awid;
            w_idx <= word_idx(s_axi_awaddr);
            w_len <= s_axi_awlen;
            w_cnt <= '0;
            w_ok <= aw_ok;
            w_err <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt + 8'd1;
            w_err <= w_err | w_bad;
            if (w_final) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp <= (w_err || w_bad || !w_ok) ? 2'b10 : 2'b00;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM byte-lane write; contents survive reset
  always_ff @(posedge s_axi_aclk) begin
    if (w_fire && w_ok) begin
      for (int b = 0; b < SW; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  r_state_t r_state;
  logic [IW-1:0] r_idx, r_nidx, ar_idx;
  logic [7:0] r_len, r_cnt;
  logic r_ok;

  assign ar_idx = word_idx(s_axi_araddr);
  assign r_nidx = r_idx + 1'b1;

  // Read channel FSM: data registered from RAM, held stable under stall
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rlast <= 1'b0;
      s_axi_rresp <= 2'b00;
      s_axi_rid <= '0;
      s_axi_rdata <= '0;
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_ok <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid <= 1'b1;
            s_axi_rid <= s_axi_arid;
            s_axi_rdata <= ar_ok ? mem[ar_idx] : '0;
            s_axi_rresp <= ar_ok ? 2'b00 : 2'b10;
            s_axi_rlast <= (s_axi_arlen == 8'd0);
            r_idx <= ar_idx;
            r_len <= s_axi_arlen;
            r_cnt <= '0;
            r_ok <= ar_ok;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rvalid && s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid <= 1'b0;
              s_axi_rlast <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_idx <= r_nidx;
              r_cnt <= r_cnt + 8'd1;
              s_axi_rdata <= r_ok ? mem[r_nidx] : '0;
              s_axi_rlast <= (r_cnt + 8'd1 == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_ram.sv
// tb_axi_slave_ram: table vectors plus burst sequences, scoreboarded reads.
// Build with AXI_SLV_RANGE_CHECK_EN to cover the range-check variant.
`timescale 1ns/1ps
module tb_axi_slave_ram;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:0] awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  axi_slave_ram #(
    .S_SLAVE_BASE_ADDR(BASE),
    .S_AXI_ID_WIDTH(1),
    .S_AXI_DATA_WIDTH(32),
    .S_MEM_DEPTH(DEPTH)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic last;
    logic [1:0] resp;
    logic [0:0] id;
  } rexp_t;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wbuf [256];
  rexp_t sq[$];
  vec_t tbl[7];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
`ifdef AXI_SLV_RANGE_CHECK_EN
    return (a - BASE) < 32'(DEPTH * 4);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] w;
    w = (a - BASE) >> 2;
    return int'(w % 32'(DEPTH));
  endfunction

  task automatic check_reset(input string nm);
    check(nm, {awready, wready, bvalid, arready, rvalid, rlast,
               bresp, rresp, bid, rid, rdata}, 64'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input int len,
                          input int last_at, input logic [3:0] strb,
                          input logic [0:0] id, input string nm);
    int t;
    int bi;
    bit ok;
    logic [1:0] eresp;
    bi = widx(addr);
    ok = in_range(addr);
    eresp = (ok && last_at == len) ? 2'b00 : 2'b10;
    awaddr = addr;
    awlen = 8'(len);
    awid = id;
    awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({nm, " awready"}, awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wdata = wbuf[b];
      wstrb = strb;
      wlast = (b == last_at);
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!wready) begin
        check({nm, " wready"}, wready, 1);
        break;
      end
      if (ok) begin
        for (int k = 0; k < 4; k++) begin
          if (strb[k]) model[(bi + b) % DEPTH][8*k +: 8] = wbuf[b][8*k +: 8];
        end
      end
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({nm, " b"}, {bvalid, bid, bresp}, {1'b1, id, eresp});
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len,
                         input logic [0:0] id, input bit toggle,
                         input bit use_exp, input logic [31:0] exp0,
                         input string nm);
    int t;
    int bi;
    int cyc;
    int stalls;
    bit ok;
    rexp_t e;
    bi = widx(addr);
    ok = in_range(addr);
    for (int b = 0; b <= len; b++) begin
      e.data = !ok ? 32'd0 : (use_exp ? exp0 : model[(bi + b) % DEPTH]);
      e.last = (b == len);
      e.resp = ok ? 2'b00 : 2'b10;
      e.id = id;
      sq.push_back(e);
    end
    araddr = addr;
    arlen = 8'(len);
    arid = id;
    arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({nm, " arready"}, arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    cyc = 0;
    stalls = 0;
    while (sq.size() > 0 && cyc < 2000) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (!rvalid) begin
        stalls++;
      end else begin
        e = sq[0];
        check({nm, " r"}, {rdata, rlast, rresp, rid},
              {e.data, e.last, e.resp, e.id});
        if (rready) void'(sq.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    if (sq.size() > 0) begin
      check({nm, " beats left"}, 64'(sq.size()), 64'd0);
      sq.delete();
    end
    if (!toggle) check({nm, " stall cycles"}, 64'(stalls), 64'd0);
    check({nm, " rvalid low"}, rvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int bi;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
    rready = 1'b0;

    tbl[0] = '{32'h4000_0040, 32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD};
    tbl[1] = '{32'h4000_0040, 32'h0000_1122, 4'h3, 32'hAABB_1122};
    tbl[2] = '{32'h4000_0040, 32'h99FF_FFFF, 4'h8, 32'h99BB_1122};
    tbl[3] = '{32'h4000_0040, 32'hFFFF_FFFF, 4'h0, 32'h99BB_1122};
    tbl[4] = '{32'h4000_0FFC, 32'h1234_5678, 4'hF, 32'h1234_5678};
    tbl[5] = '{32'h4000_0FFC, 32'hABCD_EF00, 4'h6, 32'h12CD_EF78};
    tbl[6] = '{32'h4000_0000, 32'hCAFE_BABE, 4'hF, 32'hCAFE_BABE};

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle ready", {awready, arready, wready, bvalid, rvalid},
          5'b11000);

    for (int i = 0; i < 7; i++) begin
      wbuf[0] = tbl[i].data;
      do_write(tbl[i].addr, 0, 0, tbl[i].strb, 1'b0, "tbl wr");
      do_read(tbl[i].addr, 0, 1'b1, 1'b0, 1'b1, tbl[i].exp, "tbl rd");
    end

    for (int b = 0; b < 16; b++) wbuf[b] = 32'(b);
    do_write(BASE, 15, 15, 4'hF, 1'b1, "burst16 wr");
    do_read(BASE, 15, 1'b0, 1'b0, 1'b0, 32'd0, "burst16 rd");

    for (int b = 0; b < 4; b++) wbuf[b] = 32'h0000_0100 + 32'(b);
    do_write(32'h4000_0100, 3, 1, 4'hF, 1'b0, "early wlast wr");
    do_read(32'h4000_0100, 3, 1'b0, 1'b0, 1'b0, 32'd0, "early wlast rd");
    do_write(32'h4000_0110, 1, -1, 4'hF, 1'b1, "no wlast wr");

    do_read(BASE, 7, 1'b1, 1'b1, 1'b0, 32'd0, "stall rd");

    for (int b = 0; b < 256; b++) wbuf[b] = $urandom;
    do_write(32'h4000_0F00, 255, 255, 4'hF, 1'b1, "len256 wr");
    do_read(32'h4000_0F00, 255, 1'b1, 1'b0, 1'b0, 32'd0, "len256 rd");

    wbuf[0] = 32'hDEAD_BEEF;
    do_write(32'h5000_0000, 0, 0, 4'hF, 1'b0, "far wr");
    do_read(32'h5000_0000, 0, 1'b0, 1'b0, 1'b0, 32'd0, "far rd");
    do_read(BASE, 0, 1'b0, 1'b0, 1'b0, 32'd0, "word0 rd");

    for (int b = 0; b < 8; b++) wbuf[b] = 32'h5500_0000 + 32'(b);
    do_write(32'h4000_0200, 7, 7, 4'hF, 1'b0, "pre wr");
    bi = widx(32'h4000_0200);
    awaddr = 32'h4000_0200;
    awlen = 8'd7;
    awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("mid aw", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wdata = 32'h7700_0000 + 32'(b);
      wstrb = 4'hF;
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("mid w", wready, 1);
      model[bi + b] = wdata;
      @(negedge clk);
    end
    wdata = 32'h7700_0002;
    rst_n = 1'b0;
    #1;
    check_reset("mid reset");
    wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post reset ready", {awready, arready, wready, bvalid}, 4'b1100);
    do_read(32'h4000_0200, 7, 1'b0, 1'b0, 1'b0, 32'd0, "abandoned rd");
    for (int b = 0; b < 8; b++) wbuf[b] = 32'h6600_0000 + 32'(b);
    do_write(32'h4000_0200, 7, 7, 4'hF, 1'b1, "after rst wr");
    do_read(32'h4000_0200, 7, 1'b1, 1'b0, 1'b0, 32'd0, "after rst rd");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axi_slave_ram.md
AXI_SLAVE_RAM -- requirements
Module: axi_slave_ram

Interface
REQ-001 SHALL have parameter S_SLAVE_BASE_ADDR, default 32'h4000_0000: byte address of memory word 0.
REQ-002 SHALL have parameter S_AXI_ID_WIDTH, default 1: width of all ID fields.
REQ-003 SHALL have parameter S_AXI_DATA_WIDTH, default 32: data width in bits (32 or 64).
REQ-004 SHALL have parameter S_MEM_DEPTH, default 1024: number of data words, power of two.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- s_axi_aclk, in, 1: clock, all logic on rising edge.
- s_axi_aresetn, in, 1: asynchronous active-low reset.
- s_axi_awid, in, ID: write burst ID.
- s_axi_awaddr, in, 32: write start byte address.
- s_axi_awlen, in, 8: write beats minus 1.
- s_axi_awvalid / s_axi_awready, in / out, 1: AW handshake.
- s_axi_wdata, in, DATA: write data.
- s_axi_wstrb, in, DATA/8: byte enables.
- s_axi_wlast, in, 1: last write beat.
- s_axi_wvalid / s_axi_wready, in / out, 1: W handshake.
- s_axi_bid, out, ID: echoed awid.
- s_axi_bresp, out, 2: write response.
- s_axi_bvalid / s_axi_bready, out / in, 1: B handshake.
- s_axi_arid, in, ID: read burst ID.
- s_axi_araddr, in, 32: read start byte address.
- s_axi_arlen, in, 8: read beats minus 1.
- s_axi_arvalid / s_axi_arready, in / out, 1: AR handshake.
- s_axi_rid, out, ID: echoed arid.
- s_axi_rdata, out, DATA: read data.
- s_axi_rresp, out, 2: read response.
- s_axi_rlast, out, 1: last read beat.
- s_axi_rvalid / s_axi_rready, out / in, 1: R handshake.

Function
REQ-006 SHALL treat every burst as INCR with full-width beats; the word index SHALL be (addr - S_SLAVE_BASE_ADDR) >> log2(DATA/8), incrementing by 1 per beat and wrapping modulo S_MEM_DEPTH.
REQ-007 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP. awready=1 only in W_IDLE. An AW handshake SHALL latch id, index and length and move to W_DATA. In W_DATA, wready=1. Each W handshake SHALL write the bytes enabled by wstrb and advance the index. The handshake on beat awlen+1 SHALL move to W_RESP. In W_RESP, bvalid=1 until bready=1, then return to W_IDLE.
REQ-008 bresp SHALL be 2'b10 (SLVERR) if wlast does not match the final-beat position on any beat, otherwise 2'b00 (OKAY). The burst length SHALL always be awlen+1 beats, independent of wlast.
REQ-009 Read FSM SHALL have states R_IDLE and R_DATA. arready=1 only in R_IDLE. An AR handshake SHALL move to R_DATA, with rvalid asserted the next cycle carrying word 0.
REQ-010 rdata/rid/rresp/rlast SHALL stay stable while rvalid=1 and rready=0. Each R handshake SHALL present the next beat in the following cycle (one beat per cycle with rready held high). rlast=1 only on beat arlen+1. Its handshake SHALL return the FSM to R_IDLE.
REQ-011 Read and write FSMs SHALL run concurrently. A same-cycle read and write of the same word SHALL return the old data.
REQ-012 awlen=0 / arlen=0 SHALL give single-beat bursts; awlen=255 SHALL be supported.

Reset
REQ-013 While s_axi_aresetn=0, the following SHALL all be 0 and both FSMs SHALL be idle: awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata.
REQ-014 Memory contents SHALL NOT be cleared by reset. Reset mid-burst SHALL abandon the burst with no further write.

Configuration
REQ-015 With AXI_SLV_RANGE_CHECK_EN defined, a burst whose start byte address lies outside [S_SLAVE_BASE_ADDR, S_SLAVE_BASE_ADDR + S_MEM_DEPTH*DATA/8) SHALL complete all handshakes, suppress memory writes, return rdata=0, and respond 2'b10.
REQ-016 Without AXI_SLV_RANGE_CHECK_EN, all addresses SHALL map per REQ-006 with OKAY response (except REQ-008).

Verification
REQ-017 AW addr 32'h4000_0000, awlen=15, data 0..15, wstrb all 1s, wlast on beat 16 -> bresp 2'b00; AR same address, arlen=15 -> rdata 0..15, rlast on beat 16 only.
REQ-018 Write word 32'hAABB_CCDD, then overwrite with wstrb=4'b0011 and data 32'h0000_1122 -> read returns 32'hAABB_1122.
REQ-019 awlen=3 with wlast asserted on beat 2 -> 4 beats accepted, bresp 2'b10.
REQ-020 Read with arlen=7 and rready toggling 1/0 every cycle -> 8 beats, data stable across stalls, rid equals arid.
REQ-021 With AXI_SLV_RANGE_CHECK_EN defined, write to 32'h5000_0000 -> bresp 2'b10 and memory unchanged; read of the same address -> rdata 0, rresp 2'b10.
REQ-022 Assert s_axi_aresetn=0 during beat 3 of an 8-beat write -> all outputs 0 immediately; after release, awready=1 and the next burst completes normally.
